// File: rtl/lcd_st_arb_pkg.sv
// Shared types and defaults for the LCD FIFO write-side packet arbiter.
// Beats travel between the arbiter and its skid buffer as {data, sop, eop}.
package lcd_st_arb_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  sop;
        logic                  eop;
    } beat_t;

endpackage

// File: rtl/lcd_st_skid_buffer.sv
// Two-entry registered ready/valid stage. Outputs come straight from the head
// register and in_ready depends only on the occupancy register.
module lcd_st_skid_buffer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic [1:0]   occ_q;
    logic         push;
    logic         pop;

    assign in_ready  = (occ_q < 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (push) begin
                        head_q <= in_data;
                        occ_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    // Push with pop replaces the head in place, keeping one beat per cycle.
                    if (push && pop) begin
                        head_q <= in_data;
                    end else if (push) begin
                        tail_q <= in_data;
                        occ_q  <= 2'd2;
                    end else if (pop) begin
                        occ_q  <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q <= tail_q;
                        occ_q  <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_st_packet_arbiter.sv
// Packet-level round-robin arbiter feeding the LCD on-chip FIFO write side from
// two Avalon-ST pixel producers; grant is held from SOP until EOP.
module lcd_st_packet_arbiter
    import lcd_st_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_valid,
    input  logic              s0_sop,
    input  logic              s0_eop,
    output logic              s0_ready,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_valid,
    input  logic              s1_sop,
    input  logic              s1_eop,
    output logic              s1_ready,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    output logic              src_sop,
    output logic              src_eop,
    input  logic              src_ready,
    output logic [1:0]        grant,
    output logic [CNT_W-1:0]  drop_count,
    output logic              proto_err
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } pbeat_t;

    localparam int BEAT_W = $bits(pbeat_t);

    arb_state_e      state;
    arb_state_e      state_nxt;
    logic            last_grant;
    logic            first_beat;
    logic            elig0, elig1, stray0, stray1;
    logic            rdy0, rdy1;
    logic            push;
    pbeat_t          push_beat;
    logic            buf_in_ready;
    logic [BEAT_W-1:0] head_vec;
    pbeat_t          head_beat;
    logic [1:0]      drop_inc;
    logic [CNT_W:0]  drop_sum;

    assign elig0  = s0_valid & s0_sop;
    assign elig1  = s1_valid & s1_sop;
    assign stray0 = s0_valid & ~s0_sop;
    assign stray1 = s1_valid & ~s1_sop;

    always_comb begin
        state_nxt = state;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        push      = 1'b0;
        push_beat = '0;
        case (state)
            IDLE: begin
                // SOP beats wait for the grant; only stray beats are taken here.
                rdy0 = stray0;
                rdy1 = stray1;
                if (elig0 && (!elig1 || last_grant))
                    state_nxt = GRANT0;
                else if (elig1)
                    state_nxt = GRANT1;
            end
            GRANT0: begin
                rdy0      = buf_in_ready;
                push      = s0_valid & buf_in_ready;
                push_beat = '{data: s0_data, sop: s0_sop, eop: s0_eop};
                if (push && s0_eop)
                    state_nxt = IDLE;
            end
            GRANT1: begin
                rdy1      = buf_in_ready;
                push      = s1_valid & buf_in_ready;
                push_beat = '{data: s1_data, sop: s1_sop, eop: s1_eop};
                if (push && s1_eop)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is held low while reset is asserted so no producer sees a transfer.
    assign s0_ready = rdy0 & reset_n;
    assign s1_ready = rdy1 & reset_n;

    always_comb begin
        drop_inc = 2'd0;
        if (state == IDLE)
            drop_inc = {1'b0, stray0} + {1'b0, stray1};
        drop_sum = {1'b0, drop_count} + (CNT_W+1)'(drop_inc);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            first_beat <= 1'b0;
            grant      <= 2'b00;
            drop_count <= '0;
            proto_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            grant <= {state_nxt == GRANT1, state_nxt == GRANT0};
            if (state == IDLE)
                first_beat <= 1'b1;
            else if (push)
                first_beat <= 1'b0;
            if (push && push_beat.eop)
                last_grant <= (state == GRANT1);
            if (push && push_beat.sop && !first_beat)
                proto_err <= 1'b1;
            drop_count <= drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
        end
    end

    lcd_st_skid_buffer #(
        .W(BEAT_W)
    ) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (push_beat),
        .in_valid (push),
        .in_ready (buf_in_ready),
        .out_data (head_vec),
        .out_valid(src_valid),
        .out_ready(src_ready)
    );

    assign head_beat = head_vec;
    assign src_data  = head_beat.data;
    assign src_sop   = head_beat.sop;
    assign src_eop   = head_beat.eop;

endmodule

// File: tb/tb_lcd_st_packet_arbiter.sv
// Bench for lcd_st_packet_arbiter: queue-based producers, a transaction-level
// model of arbitration and buffering, and per-cycle output comparison.
module tb_lcd_st_packet_arbiter;

    localparam int DMAX = 255;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] s0_data = '0, s1_data = '0;
    logic       s0_valid = 1'b0, s0_sop = 1'b0, s0_eop = 1'b0, s0_ready;
    logic       s1_valid = 1'b0, s1_sop = 1'b0, s1_eop = 1'b0, s1_ready;
    logic [7:0] src_data;
    logic       src_valid, src_sop, src_eop;
    logic       src_ready = 1'b0;
    logic [1:0] grant;
    logic [7:0] drop_count;
    logic       proto_err;

    int n_cmp = 0;
    int n_err = 0;
    int vprob = 100;
    int rprob = 100;

    logic [9:0] txq0[$], txq1[$];
    bit         rdy_pat[$];
    logic [9:0] out_log[$];
    logic [1:0] grant_log[$];

    // model state: owner -1 = idle, queue = beats sitting in front of the FIFO
    int         m_owner, m_last, m_drop;
    bit         m_first, m_perr;
    logic [9:0] m_q[$];

    lcd_st_packet_arbiter #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_sop(s0_sop), .s0_eop(s0_eop), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_sop(s1_sop), .s1_eop(s1_eop), .s1_ready(s1_ready),
        .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_ready(src_ready), .grant(grant), .drop_count(drop_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_owner = -1; m_last = 1; m_first = 0; m_perr = 0; m_drop = 0;
        m_q.delete();
    endtask

    task automatic m_step();
        bit v[2], s[2], pop, acc;
        logic [9:0] b[2];
        logic [9:0] nb;
        v[0] = s0_valid; s[0] = s0_sop; b[0] = {s0_data, s0_sop, s0_eop};
        v[1] = s1_valid; s[1] = s1_sop; b[1] = {s1_data, s1_sop, s1_eop};
        pop = (m_q.size() > 0) && src_ready;
        acc = 0;
        nb  = '0;
        if (m_owner < 0) begin
            for (int p = 0; p < 2; p++)
                if (v[p] && !s[p]) m_drop = (m_drop < DMAX) ? m_drop + 1 : DMAX;
            if (v[0] && s[0] && (!(v[1] && s[1]) || m_last == 1)) m_owner = 0;
            else if (v[1] && s[1]) m_owner = 1;
            m_first = 1;
        end else if (v[m_owner] && m_q.size() < 2) begin
            acc = 1;
            nb  = b[m_owner];
            if (nb[1] && !m_first) m_perr = 1;
            m_first = 0;
            if (nb[0]) begin m_last = m_owner; m_owner = -1; end
        end
        if (pop) void'(m_q.pop_front());
        if (acc) m_q.push_back(nb);
    endtask

    function automatic bit exp_ready(input int p, input bit v, input bit s);
        if (!reset_n) return 1'b0;
        if (m_owner < 0) return v && !s;
        if (m_owner == p) return m_q.size() < 2;
        return 1'b0;
    endfunction

    // model
    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) m_reset();
            else m_step();
        end
    end

    // producers and sink
    initial begin
        bit xf0, xf1;
        forever begin
            @(negedge clk);
            xf0 = s0_valid & s0_ready;
            xf1 = s1_valid & s1_ready;
            @(posedge clk);
            #1;
            if (xf0 && txq0.size() > 0) void'(txq0.pop_front());
            if (xf1 && txq1.size() > 0) void'(txq1.pop_front());
            if (txq0.size() > 0 && $urandom_range(99) < vprob) begin
                s0_valid = 1'b1; {s0_data, s0_sop, s0_eop} = txq0[0];
            end else s0_valid = 1'b0;
            if (txq1.size() > 0 && $urandom_range(99) < vprob) begin
                s1_valid = 1'b1; {s1_data, s1_sop, s1_eop} = txq1[0];
            end else s1_valid = 1'b0;
            if (rdy_pat.size() > 0) src_ready = rdy_pat.pop_front();
            else src_ready = ($urandom_range(99) < rprob);
        end
    end

    // compare process
    initial begin
        logic [1:0] prev_grant;
        logic [1:0] eg;
        prev_grant = 2'b00;
        forever begin
            @(negedge clk);
            eg = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
            chk("grant", grant, eg);
            chk("s0_ready", s0_ready, exp_ready(0, s0_valid, s0_sop));
            chk("s1_ready", s1_ready, exp_ready(1, s1_valid, s1_sop));
            chk("src_valid", src_valid, m_q.size() > 0);
            if (m_q.size() > 0) chk("src_beat", {src_data, src_sop, src_eop}, m_q[0]);
            chk("drop_count", drop_count, m_drop);
            chk("proto_err", proto_err, m_perr);
            if (src_valid === 1'b1 && src_ready) out_log.push_back({src_data, src_sop, src_eop});
            if (prev_grant == 2'b00 && grant != 2'b00) grant_log.push_back(grant);
            prev_grant = grant;
        end
    end

    task automatic add_pkt(input int p, input int len, input logic [7:0] base, input int sop_at);
        logic [9:0] b;
        for (int k = 0; k < len; k++) begin
            b = {base + 8'(k), (k == 0) || (k == sop_at), k == len - 1};
            if (p == 0) txq0.push_back(b); else txq1.push_back(b);
        end
    endtask

    task automatic add_stray(input int p, input logic [7:0] d, input bit e);
        if (p == 0) txq0.push_back({d, 1'b0, e}); else txq1.push_back({d, 1'b0, e});
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(txq0.size() == 0 && txq1.size() == 0 && !s0_valid && !s1_valid &&
                     m_q.size() == 0 && m_owner < 0) && n < 20000);
        if (n >= 20000) begin
            n_cmp++; n_err++;
            $display("FAIL %s: drain timeout, got busy expected idle", nm);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        txq0.delete(); txq1.delete(); rdy_pat.delete();
        @(posedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int ob, gb, n, nbeats, nstray, len, p;
        bit found;
        logic [9:0] e;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_src_valid", src_valid, 1'b0);
        chk("rst_src_data", src_data, 8'h00);
        chk("rst_drop", drop_count, 8'h00);
        chk("rst_perr", proto_err, 1'b0);
        reset_n = 1'b1;

        // single 4-beat packet on port 0
        ob = out_log.size(); gb = grant_log.size();
        add_pkt(0, 4, 8'hA0, -1);
        wait_idle("t1");
        chk("t1_count", out_log.size() - ob, 4);
        for (int k = 0; k < 4; k++) begin
            e = {8'hA0 + 8'(k), k == 0, k == 3};
            if (out_log.size() > ob + k) chk("t1_beat", out_log[ob + k], e);
        end
        if (grant_log.size() > gb) chk("t1_grant", grant_log[gb], 2'b01);
        chk("t1_idle_grant", grant, 2'b00);

        // three back-to-back ties from reset
        apply_reset();
        ob = out_log.size(); gb = grant_log.size();
        for (int k = 0; k < 3; k++) begin
            add_pkt(0, 2, 8'h10 + 8'(2 * k), -1);
            add_pkt(1, 2, 8'h20 + 8'(2 * k), -1);
        end
        wait_idle("t2");
        chk("t2_grants", grant_log.size() - gb, 6);
        for (int k = 0; k < 6; k++)
            if (grant_log.size() > gb + k) chk("t2_order", grant_log[gb + k], (k % 2 == 0) ? 2'b01 : 2'b10);
        for (int k = 0; k < 12; k++) begin
            e = {((k / 2) % 2 == 0 ? 8'h10 : 8'h20) + 8'(2 * (k / 4)) + 8'(k % 2), k % 2 == 0, k % 2 == 1};
            if (out_log.size() > ob + k) chk("t2_beat", out_log[ob + k], e);
        end

        // stray beats, then saturation
        ob = out_log.size();
        for (int k = 0; k < 3; k++) add_stray(1, 8'h30 + 8'(k), 1'b0);
        wait_idle("t3a");
        chk("t3_drop3", drop_count, 8'd3);
        chk("t3_no_out", out_log.size() - ob, 0);
        for (int k = 0; k < 300; k++) add_stray(1, 8'(k), k[0]);
        wait_idle("t3b");
        chk("t3_sat", drop_count, 8'hFF);

        // 8-beat packet under a stuttering sink
        ob = out_log.size();
        for (int k = 0; k < 60; k++) rdy_pat.push_back(k % 5 == 0 || k % 5 == 3);
        add_pkt(0, 8, 8'h80, -1);
        wait_idle("t4");
        chk("t4_count", out_log.size() - ob, 8);
        for (int k = 0; k < 8; k++) begin
            e = {8'h80 + 8'(k), k == 0, k == 7};
            if (out_log.size() > ob + k) chk("t4_beat", out_log[ob + k], e);
        end

        // mid-packet SOP
        ob = out_log.size();
        add_pkt(0, 4, 8'h40, 2);
        wait_idle("t5");
        chk("t5_perr", proto_err, 1'b1);
        if (out_log.size() > ob + 2) chk("t5_fwd", out_log[ob + 2], {8'h42, 1'b1, 1'b0});

        // reset during beat 2 of a 5-beat packet (port 0 was last owner)
        add_pkt(0, 5, 8'h50, -1);
        n = 0; found = 0;
        while (n < 50 && !found) begin
            @(negedge clk); n++;
            if (s0_valid && s0_ready && s0_data == 8'h52) found = 1;
        end
        chk("t6_beat2_seen", found, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_src_valid", src_valid, 1'b0);
        chk("t6_grant", grant, 2'b00);
        chk("t6_drop", drop_count, 8'h00);
        chk("t6_perr", proto_err, 1'b0);
        chk("t6_s0_ready", s0_ready, 1'b0);
        repeat (2) @(posedge clk);
        txq0.delete(); txq1.delete();
        @(posedge clk);
        @(negedge clk);
        #1 reset_n = 1'b1;
        add_pkt(0, 2, 8'h60, -1);
        add_pkt(1, 2, 8'h70, -1);
        n = 0;
        do begin @(negedge clk); n++; end while (grant == 2'b00 && n < 20);
        chk("t6_first_grant", grant, 2'b01);
        wait_idle("t6");

        // randomized traffic
        apply_reset();
        vprob = 70; rprob = 60;
        ob = out_log.size(); nbeats = 0; nstray = 0;
        for (int i = 0; i < 150; i++) begin
            p = int'($urandom_range(1));
            if ($urandom_range(5) == 0) begin
                add_stray(p, 8'($urandom_range(255)), 1'($urandom_range(1)));
                nstray++;
            end
            len = int'($urandom_range(6, 1));
            add_pkt(p, len, 8'($urandom_range(255)), ($urandom_range(19) == 0) ? 1 : -1);
            nbeats += len;
        end
        wait_idle("rand");
        chk("rand_beats", out_log.size() - ob, nbeats);
        chk("rand_drops", drop_count, (nstray < DMAX) ? nstray : DMAX);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
